reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/tx_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/reg_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_reg_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the register-write arbiter: data width and FSM state type.
package tx_pkg;

    // Default register data width.
    localparam int WIDTH = 8;

    // Transaction sequencer states; every non-IDLE state lasts exactly one cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    // True for every state in which a transaction is in flight.
    function automatic logic state_active(arb_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or above
// ptr (wrapping modulo NUM_REQ) as a one-hot vector. Holds no state.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_first;
    logic [NUM_REQ-1:0] rot_unused;
    logic [NUM_REQ-1:0] back_unused;

    // Rotate requests so that requester ptr lands on bit 0; the upper copy
    // of the doubled vector is only there to supply the wrapped bits.
    assign {rot_unused, rot} = {req, req} >> ptr;

    // Isolate the lowest set bit: nearest requester at or after ptr.
    assign rot_first = rot & (~rot + ONE);

    // Rotate the single hot bit back to its real requester position.
    assign {winner, back_unused} = {rot_first, rot_first} << ptr;

    assign valid = |req;

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter that serialises register writes from NUM_REQ requesters.
// Each transaction runs IDLE -> GRANT -> WRITE -> CHECK -> DONE, one cycle per
// non-IDLE state. Optional readback comparison is compiled in with the macro
// REG_ARB_READBACK_EN; without it err is tied low and reg_outa is ignored.
module reg_arbiter #(
    parameter int WIDTH   = tx_pkg::WIDTH,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     reg_enable,
    output logic [WIDTH-1:0]         reg_data,
    output logic                     reg_reset_n,
    input  logic [WIDTH-1:0]         reg_outa,
    output logic                     busy,
    output logic                     err
);

    import tx_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] win_reg, win_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic [WIDTH-1:0]   reg_data_reg, reg_data_next;
    logic               reg_enable_reg, reg_enable_next;
    logic               rst_stage_reg;
    logic               reg_reset_n_reg;

    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [WIDTH-1:0]   masked [NUM_REQ];
    logic [WIDTH-1:0]   pick_data;
    logic [PTR_W-1:0]   win_idx;

`ifdef REG_ARB_READBACK_EN
    logic               err_reg, err_next;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_reg),
        .winner  (pick),
        .valid   (pick_valid)
    );

    // Mask each requester's data slice with its pick bit so the OR below
    // yields only the winner's data.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked[gi] = wdata[gi*WIDTH +: WIDTH] & {WIDTH{pick[gi]}};
        end
    endgenerate

    // OR-reduce the masked slices into the selected write data.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_data = pick_data | masked[i];
        end
    end

    // Encode the latched one-hot winner as an index for the pointer update.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_reg[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        win_next        = win_reg;
        data_next       = data_reg;
        gnt_next        = '0;
        done_next       = '0;
        reg_enable_next = 1'b0;
        reg_data_next   = reg_data_reg;
`ifdef REG_ARB_READBACK_EN
        err_next        = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Only start once the downstream register is out of reset.
                if (reg_reset_n_reg && pick_valid) begin
                    state_next = GRANT;
                    win_next   = pick;
                    data_next  = pick_data;
                    gnt_next   = pick;
                end
            end
            GRANT: begin
                state_next      = WRITE;
                gnt_next        = win_reg;
                reg_enable_next = 1'b1;
                reg_data_next   = data_reg;
            end
            WRITE: begin
                state_next = CHECK;
                gnt_next   = win_reg;
            end
            CHECK: begin
                state_next = DONE;
                gnt_next   = win_reg;
                done_next  = win_reg;
`ifdef REG_ARB_READBACK_EN
                if (reg_outa != data_reg) begin
                    err_next = 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Hold the register's active-low reset for one extra cycle after reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_stage_reg   <= 1'b0;
            reg_reset_n_reg <= 1'b0;
        end else begin
            rst_stage_reg   <= 1'b1;
            reg_reset_n_reg <= rst_stage_reg;
        end
    end

    // State, pointer, latched transaction and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            win_reg        <= '0;
            data_reg       <= '0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            reg_enable_reg <= 1'b0;
            reg_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            win_reg        <= win_next;
            data_reg       <= data_next;
            gnt_reg        <= gnt_next;
            done_reg       <= done_next;
            reg_enable_reg <= reg_enable_next;
            reg_data_reg   <= reg_data_next;
        end
    end

`ifdef REG_ARB_READBACK_EN
    // Sticky readback-mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    logic [WIDTH-1:0] reg_outa_unused;
    assign reg_outa_unused = reg_outa;
    assign err             = 1'b0;
`endif

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign reg_enable  = reg_enable_reg;
    assign reg_data    = reg_data_reg;
    assign reg_reset_n = reg_reset_n_reg;
    assign busy        = state_active(state_reg);

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: a transaction-level reference model
// predicts every output each cycle, plus directed literal scenarios.
module tb_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef REG_ARB_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic           clk    = 1'b0;
    logic           reset  = 1'b1;
    logic [N-1:0]   req    = '0;
    logic [N*W-1:0] wdata  = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           reg_enable;
    logic [W-1:0]   reg_data;
    logic           reg_reset_n;
    logic [W-1:0]   reg_outa;
    logic           busy;
    logic           err;

    logic [W-1:0]   ext_q  = '0;
    logic           bad    = 1'b0;
    bit             cmp_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int           m_phase = 0;
    int           m_ptr   = 0;
    int           m_win   = 0;
    int           m_rcnt  = 0;
    logic [W-1:0] m_data  = '0;
    logic [W-1:0] m_last  = '0;
    bit           m_err   = 1'b0;

    always #5 clk = ~clk;

    reg_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wdata       (wdata),
        .gnt         (gnt),
        .done        (done),
        .reg_enable  (reg_enable),
        .reg_data    (reg_data),
        .reg_reset_n (reg_reset_n),
        .reg_outa    (reg_outa),
        .busy        (busy),
        .err         (err)
    );

    // The external register being written; bad forces a broken readback.
    always @(posedge clk) begin
        if (!reg_reset_n) ext_q <= '0;
        else if (reg_enable) ext_q <= reg_data;
    end
    assign reg_outa = bad ? '0 : ext_q;

    // Transaction-level model: phase counts cycles since the grant.
    always @(posedge clk) begin
        bit ready;
        int idx;
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_win = 0; m_rcnt = 0;
            m_data = '0; m_last = '0; m_err = 1'b0;
        end else begin
            ready = (m_rcnt >= 2);
            if (m_rcnt < 2) m_rcnt++;
            if (m_phase == 0) begin
                if (ready && req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (req[idx]) begin
                            m_win   = idx;
                            m_data  = wdata[idx*W +: W];
                            m_phase = 1;
                            break;
                        end
                    end
                end
            end else if (m_phase == 3) begin
                if (RB && reg_outa != m_data) m_err = 1'b1;
                m_phase = 4;
            end else if (m_phase == 4) begin
                m_ptr   = (m_win + 1) % N;
                m_phase = 0;
            end else begin
                if (m_phase == 1) m_last = m_data;
                m_phase++;
            end
        end
    end

    function automatic logic [N-1:0] f_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_phase != 0) v[m_win] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] f_done();
        logic [N-1:0] v;
        v = '0;
        if (m_phase == 4) v[m_win] = 1'b1;
        return v;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [2*N+W+3:0] e_v;
        logic [2*N+W+3:0] g_v;
        if (cmp_en) begin
            e_v = {f_gnt(), f_done(), (m_phase == 2), m_last, (m_rcnt >= 2), (m_phase != 0), m_err};
            g_v = {gnt, done, reg_enable, reg_data, reg_reset_n, busy, err};
            n_total++;
            if (g_v !== e_v)
                $display("FAIL model_cycle t=%0t got gnt=%b done=%b en=%b data=%h rstn=%b busy=%b err=%b required gnt=%b done=%b en=%b data=%h rstn=%b busy=%b err=%b",
                         $time, gnt, done, reg_enable, reg_data, reg_reset_n, busy, err,
                         f_gnt(), f_done(), (m_phase == 2), m_last, (m_rcnt >= 2), (m_phase != 0), m_err);
            else
                n_pass++;
            if (done != '0)
                $display("txn t=%0t done=%b data=%h err=%b", $time, done, reg_data, err);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h required %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; bad = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && busy; i++) tick();
        check("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    int g_idx [5];
    int g_t   [5];
    int g_n;
    logic [N-1:0] prev_g;
    logic [N-1:0] done_seen;
    logic [N-1:0] next_g;

    initial begin
        // Reset state
        tick();
        cmp_en = 1'b1;
        check("rst_gnt",  {28'd0, gnt}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_en",   {31'd0, reg_enable}, 32'd0);
        check("rst_data", {24'd0, reg_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err",  {31'd0, err}, 32'd0);
        check("rst_rstn", {31'd0, reg_reset_n}, 32'd0);
        reset = 1'b0;
        tick();
        check("rstn_hold", {31'd0, reg_reset_n}, 32'd0);
        tick();
        check("rstn_rise", {31'd0, reg_reset_n}, 32'd1);
        tick();

        // Single request from requester 1
        wdata[1*W +: W] = 8'hA5;
        req = 4'b0010;
        tick();
        check("single_gnt", {28'd0, gnt}, 32'h2);
        check("model_pin_gnt", {28'd0, f_gnt()}, 32'h2);
        req = '0;
        tick();
        check("single_en",   {31'd0, reg_enable}, 32'd1);
        check("single_data", {24'd0, reg_data}, 32'hA5);
        tick();
        check("single_en_off", {31'd0, reg_enable}, 32'd0);
        check("single_nodone", {28'd0, done}, 32'd0);
        tick();
        check("single_done", {28'd0, done}, 32'h2);
        check("model_pin_done", {28'd0, f_done()}, 32'h2);
        tick();
        check("single_done_off", {28'd0, done}, 32'd0);
        check("single_idle", {31'd0, busy}, 32'd0);
        check("single_outa", {24'd0, reg_outa}, 32'hA5);

        // All requesters at once from ptr=0
        do_reset();
        wdata = 32'h44332211;
        req = 4'b1111;
        g_n = 0; prev_g = '0;
        for (int i = 0; i < 5; i++) begin g_idx[i] = -1; g_t[i] = -100; end
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (gnt != '0 && prev_g == '0 && g_n < 5) begin
                for (int b = 0; b < N; b++) if (gnt[b]) g_idx[g_n] = b;
                g_t[g_n] = t;
                g_n++;
            end
            prev_g = gnt;
        end
        req = '0;
        check("rr_order0", g_idx[0], 32'd0);
        check("rr_order1", g_idx[1], 32'd1);
        check("rr_order2", g_idx[2], 32'd2);
        check("rr_order3", g_idx[3], 32'd3);
        check("rr_order4", g_idx[4], 32'd0);
        for (int i = 1; i < 5; i++) check("rr_spacing", g_t[i] - g_t[i-1], 32'd5);
        drain();

        // Data change after the grant is ignored
        do_reset();
        wdata[2*W +: W] = 8'h3C;
        req = 4'b0100;
        tick();
        check("hold_gnt", {28'd0, gnt}, 32'h4);
        req = '0;
        wdata[2*W +: W] = 8'hFF;
        tick();
        check("hold_data", {24'd0, reg_data}, 32'h3C);
        tick(); tick(); tick();
        check("hold_outa", {24'd0, reg_outa}, 32'h3C);

        // Reset during WRITE aborts and returns ptr to 0
        do_reset();
        wdata[1*W +: W] = 8'h11;
        req = 4'b0010;
        tick();
        req = '0;
        tick(); tick(); tick(); tick();
        wdata[2*W +: W] = 8'h22;
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("abort_en", {31'd0, reg_enable}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort_gnt",  {28'd0, gnt}, 32'd0);
        check("abort_done", {28'd0, done}, 32'd0);
        check("abort_rstn0", {31'd0, reg_reset_n}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_rstn1", {31'd0, reg_reset_n}, 32'd0);
        check("abort_done2", {28'd0, done}, 32'd0);
        tick();
        check("abort_rstn_up", {31'd0, reg_reset_n}, 32'd1);
        req = 4'b1010;
        tick();
        check("abort_ptr0", {28'd0, gnt}, 32'h2);
        req = '0;
        drain();

        // Late withdrawal by requester 3 while requester 0 waits
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        tick(); tick(); tick(); tick();
        req = 4'b1001;
        tick();
        check("late_gnt3", {28'd0, gnt}, 32'h8);
        req = 4'b0001;
        done_seen = '0; next_g = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_seen = done_seen | done;
            if (gnt != '0 && gnt != 4'b1000) begin next_g = gnt; break; end
        end
        check("late_done3", {28'd0, done_seen}, 32'h8);
        check("late_next0", {28'd0, next_g}, 32'h1);
        req = '0;
        drain();

`ifdef REG_ARB_READBACK_EN
        // Readback mismatch sets a sticky error
        do_reset();
        bad = 1'b1;
        wdata[0 +: W] = 8'h5A;
        req = 4'b0001;
        tick();
        req = '0;
        tick(); tick();
        check("rb_err_pre", {31'd0, err}, 32'd0);
        tick();
        check("rb_err_set", {31'd0, err}, 32'd1);
        check("rb_done", {28'd0, done}, 32'h1);
        bad = 1'b0;
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        tick(); tick(); tick();
        check("rb_next_done", {28'd0, done}, 32'h2);
        check("rb_err_sticky", {31'd0, err}, 32'd1);
        drain();
`endif

        // Randomized traffic with occasional reset and bad readback
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req   = N'($urandom) & N'($urandom);
            wdata = $urandom;
            bad   = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; bad = 1'b0; req = '0;
        for (int i = 0; i < 8; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
